// File: rtl/matrix_storage_loader_if.sv
// Record stream carrying one storage write per beat into the preload sequencer.
interface matrix_storage_loader_if #(
    parameter int unsigned CH_W        = 2,
    parameter int unsigned INDEX_WIDTH = 32,
    parameter int unsigned DATA_WIDTH  = 48
);
    logic                   rec_valid;
    logic                   rec_ready;
    logic [CH_W-1:0]        rec_channel;
    logic [INDEX_WIDTH-1:0] rec_layer;
    logic [INDEX_WIDTH-1:0] rec_row;
    logic [DATA_WIDTH-1:0]  rec_data;
    logic                   rec_last;

    modport master (
        output rec_valid, rec_channel, rec_layer, rec_row, rec_data, rec_last,
        input  rec_ready
    );

    modport slave (
        input  rec_valid, rec_channel, rec_layer, rec_row, rec_data, rec_last,
        output rec_ready
    );
endinterface

// File: rtl/matrix_storage_loader.sv
// Preload sequencer: buffers a record stream in a FIFO and drains it onto one-hot storage write
// strobes, pulses the locator reset at session start and enables the controller once the whole
// load has landed. Define LOADER_CHECKSUM_EN to add an XOR checksum of the issued write data.
module matrix_storage_loader #(
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned DATA_WIDTH   = 48,
    parameter int unsigned INDEX_WIDTH  = 32,
    parameter int unsigned FIFO_DEPTH   = 8,
    localparam int unsigned CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                         clk_clk,
    input  logic                         reset_reset_n,
    input  logic                         start,
    input  logic                         abort,
    matrix_storage_loader_if.slave       rec,
    output logic [NUM_CHANNELS-1:0]      wr_is_write,
    output logic [INDEX_WIDTH-1:0]       wr_layer_index,
    output logic [INDEX_WIDTH-1:0]       wr_row_index,
    output logic [DATA_WIDTH-1:0]        wr_data,
    output logic                         locator_reset,
    output logic                         controller_enable,
    output logic                         busy,
    output logic                         done,
    output logic [INDEX_WIDTH-1:0]       rec_count,
`ifdef LOADER_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0]        checksum,
`endif
    output logic                         err_channel
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic [2:0] {StIdle, StLocRst, StLoad, StDrain, StArm, StRun} state_e;

    typedef struct packed {
        logic [CH_W-1:0]        ch;
        logic [INDEX_WIDTH-1:0] layer;
        logic [INDEX_WIDTH-1:0] row;
        logic [DATA_WIDTH-1:0]  data;
    } rec_t;

    state_e                  state_q, state_d;
    logic [PW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
    logic [NUM_CHANNELS-1:0] strobe_q, strobe_d;
    logic [INDEX_WIDTH-1:0]  layer_q, layer_d, row_q, row_d, count_q, count_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]   ck_q, ck_d;
`endif

    rec_t fifo_mem [FIFO_DEPTH];
    rec_t rec_in, head;
    logic fifo_empty, fifo_full, ready, push, pop, head_ok;

    // Extra pointer bit tells full from empty when the indices coincide.
    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q == {~rptr_q[AW], rptr_q[AW-1:0]});
    assign ready      = (state_q == StLoad) && !fifo_full;
    assign push       = rec.rec_valid && ready;
    assign pop        = ((state_q == StLoad) || (state_q == StDrain)) && !fifo_empty && !abort;
    assign rec_in     = {rec.rec_channel, rec.rec_layer, rec.rec_row, rec.rec_data};
    assign head       = fifo_mem[rptr_q[AW-1:0]];
    assign head_ok    = (32'(head.ch) < NUM_CHANNELS);

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_clk) begin
        if (push) begin
            fifo_mem[wptr_q[AW-1:0]] <= rec_in;
        end
    end

    // Next-state, FIFO pointers and write-port registers.
    always_comb begin
        state_d  = state_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        strobe_d = '0;
        layer_d  = layer_q;
        row_d    = row_q;
        data_d   = data_q;
        count_d  = count_q;
        err_d    = err_q;
`ifdef LOADER_CHECKSUM_EN
        ck_d     = ck_q;
`endif
        if (push) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (pop) begin
            rptr_d  = rptr_q + PW'(1);
            layer_d = head.layer;
            row_d   = head.row;
            data_d  = head.data;
            if (head_ok) begin
                strobe_d = NUM_CHANNELS'(1) << head.ch;
                count_d  = count_q + INDEX_WIDTH'(1);
`ifdef LOADER_CHECKSUM_EN
                ck_d     = ck_q ^ head.data;
`endif
            end else begin
                err_d = 1'b1;
            end
        end
        unique case (state_q)
            StIdle:   if (start) state_d = StLocRst;
            StLocRst: begin
                state_d = StLoad;
                count_d = '0;
                err_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                ck_d    = '0;
`endif
            end
            StLoad:   if (push && rec.rec_last) state_d = StDrain;
            StDrain:  if (fifo_empty) state_d = StArm;
            StArm:    state_d = StRun;
            StRun:    if (start) state_d = StLocRst;
            default:  state_d = StIdle;
        endcase
        // Abort overrides everything, including a concurrent start.
        if (abort) begin
            state_d  = StIdle;
            wptr_d   = '0;
            rptr_d   = '0;
            strobe_d = '0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q  <= StIdle;
            wptr_q   <= '0;
            rptr_q   <= '0;
            strobe_q <= '0;
            layer_q  <= '0;
            row_q    <= '0;
            data_q   <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            ck_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            strobe_q <= strobe_d;
            layer_q  <= layer_d;
            row_q    <= row_d;
            data_q   <= data_d;
            count_q  <= count_d;
            err_q    <= err_d;
`ifdef LOADER_CHECKSUM_EN
            ck_q     <= ck_d;
`endif
        end
    end

    assign rec.rec_ready        = ready;
    assign wr_is_write          = strobe_q;
    assign wr_layer_index       = layer_q;
    assign wr_row_index         = row_q;
    assign wr_data              = data_q;
    assign locator_reset        = (state_q == StLocRst);
    assign controller_enable    = (state_q == StRun);
    assign done                 = (state_q == StRun);
    assign busy                 = (state_q != StIdle) && (state_q != StRun);
    assign rec_count            = count_q;
    assign err_channel          = err_q;
`ifdef LOADER_CHECKSUM_EN
    assign checksum             = ck_q;
`endif
endmodule

// File: tb/tb_matrix_storage_loader.sv
// Randomized bench for matrix_storage_loader against a queue-based model of issued writes.
// NUM_CHANNELS=5 so that channel codes 5..7 are representable and out of range.
module tb_matrix_storage_loader;
    localparam int unsigned NCH = 5;
    localparam int unsigned DW  = 48;
    localparam int unsigned IW  = 32;
    localparam int unsigned FD  = 8;
    localparam int unsigned CHW = 3;

    typedef struct packed {
        logic [NCH-1:0] strobe;
        logic [IW-1:0]  layer;
        logic [IW-1:0]  row;
        logic [DW-1:0]  data;
    } wr_t;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic [NCH-1:0] wr_is_write;
    logic [IW-1:0]  wr_layer_index, wr_row_index, rec_count;
    logic [DW-1:0]  wr_data;
    logic           locator_reset, controller_enable, busy, done, err_channel;
`ifdef LOADER_CHECKSUM_EN
    logic [DW-1:0]  checksum;
`endif

    matrix_storage_loader_if #(.CH_W(CHW), .INDEX_WIDTH(IW), .DATA_WIDTH(DW)) rec_if ();

    matrix_storage_loader #(
        .NUM_CHANNELS(NCH), .DATA_WIDTH(DW), .INDEX_WIDTH(IW), .FIFO_DEPTH(FD)
    ) dut (
        .clk_clk(clk), .reset_reset_n(rst_n), .start(start), .abort(abort), .rec(rec_if.slave),
        .wr_is_write(wr_is_write), .wr_layer_index(wr_layer_index),
        .wr_row_index(wr_row_index), .wr_data(wr_data), .locator_reset(locator_reset),
        .controller_enable(controller_enable), .busy(busy), .done(done),
        .rec_count(rec_count),
`ifdef LOADER_CHECKSUM_EN
        .checksum(checksum),
`endif
        .err_channel(err_channel)
    );

    always #5 clk = ~clk;

    wr_t         exp_q[$], obs_q[$];
    int          obs_cyc[$];
    int          exp_cnt = 0, total = 0, bad = 0, cyc = 0, en_rise_cyc = -1, locrst_n = 0;
    int          stalls = 0;
    logic        exp_err = 1'b0, en_prev = 1'b0;
    logic [DW-1:0] exp_ck = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor: logs every strobe, controller_enable rise and locator_reset cycle.
    always @(negedge clk) begin
        if (wr_is_write != '0) begin
            obs_q.push_back({wr_is_write, wr_layer_index, wr_row_index, wr_data});
            obs_cyc.push_back(cyc);
        end
        if (controller_enable && !en_prev) en_rise_cyc = cyc;
        en_prev = controller_enable;
        if (locator_reset) locrst_n++;
    end

    task automatic new_session();
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
        exp_cnt = 0; exp_err = 1'b0; exp_ck = '0; locrst_n = 0; en_rise_cyc = -1; stalls = 0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    // Offers one record (valid stays high afterwards) and updates the model.
    task automatic push_rec(input logic [CHW-1:0] ch, input logic [IW-1:0] layer,
                            input logic [IW-1:0] row, input logic [DW-1:0] data,
                            input logic last);
        int  w = 0;
        wr_t e;
        rec_if.rec_valid = 1'b1; rec_if.rec_channel = ch; rec_if.rec_layer = layer;
        rec_if.rec_row = row; rec_if.rec_data = data; rec_if.rec_last = last;
        while (!rec_if.rec_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        stalls += w;
        @(negedge clk);
        if (32'(ch) < NCH) begin
            e = {NCH'(1) << ch, layer, row, data};
            exp_q.push_back(e);
            exp_cnt++;
            exp_ck ^= data;
        end else begin
            exp_err = 1'b1;
        end
    endtask

    task automatic idle_valid();
        rec_if.rec_valid = 1'b0;
        rec_if.rec_last  = 1'b0;
    endtask

    task automatic wait_run();
        int n = 0;
        while (!controller_enable && n < 60) begin
            @(negedge clk);
            n++;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({wr_is_write, wr_layer_index, wr_row_index, wr_data, locator_reset, controller_enable,
             busy, done, rec_count, err_channel, rec_if.rec_ready} !== '0) begin
            bad++; $display("FAIL reset_outputs got nonzero output(s) want all 0");
        end
        rst_n = 1'b1;
        @(negedge clk);
        new_session();
        do_start();
        for (int i = 0; i < 3; i++)
            push_rec(CHW'($urandom_range(0, 3)), $urandom(), $urandom(),
                     DW'({$urandom(), $urandom()}), 1'b0);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({wr_is_write, wr_layer_index, wr_row_index, wr_data, locator_reset, controller_enable,
             busy, done, rec_count, err_channel, rec_if.rec_ready} !== '0) begin
            bad++; $display("FAIL reset_midload got nonzero output(s) want all 0");
        end
`ifdef LOADER_CHECKSUM_EN
        total++;
        if (checksum !== '0) begin
            bad++; $display("FAIL reset_checksum got %h want 0", checksum);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        obs_q.delete();
        // Valid held high while IDLE must be ignored.
        repeat (10) @(negedge clk);
        total++;
        if (obs_q.size() != 0) begin
            bad++; $display("FAIL reset_no_strobe got %0d strobes want 0", obs_q.size());
        end
        total++;
        if ({busy, done, rec_if.rec_ready} !== 3'b000) begin
            bad++; $display("FAIL reset_idle got busy/done/ready=%b want 000",
                            {busy, done, rec_if.rec_ready});
        end
        idle_valid();
    endtask

    task automatic test_basic();
        new_session();
        do_start();
        for (int i = 0; i < 4; i++)
            push_rec(CHW'(i), '0, IW'(i), 48'h0001_0002_0003 + DW'(i), i == 3);
        idle_valid();
        wait_run();
        total++;
        if (obs_q.size() != 4) begin
            bad++; $display("FAIL basic_count got %0d want 4", obs_q.size());
        end
        foreach (exp_q[i]) begin
            total++;
            if (obs_q[i] !== exp_q[i] || obs_cyc[i] != obs_cyc[0] + i) begin
                bad++; $display("FAIL basic_write%0d got %h at +%0d want %h at +%0d", i, obs_q[i],
                                obs_cyc[i] - obs_cyc[0], exp_q[i], i);
            end
        end
        total++;
        if (rec_count !== 32'd4 || locrst_n != 1) begin
            bad++; $display("FAIL basic_count_locrst got %0d/%0d want 4/1", rec_count, locrst_n);
        end
        total++;
        if (en_rise_cyc - obs_cyc[3] != 2) begin
            bad++; $display("FAIL basic_enable_delay got %0d want 2", en_rise_cyc - obs_cyc[3]);
        end
        total++;
        if ({done, busy, err_channel} !== 3'b100) begin
            bad++; $display("FAIL basic_run_flags got %b want 100", {done, busy, err_channel});
        end
    endtask

    task automatic test_back_to_back();
        new_session();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if ({controller_enable, locator_reset} !== 2'b01) begin
            bad++; $display("FAIL reload_enable_drop got en/locrst=%b want 01",
                            {controller_enable, locator_reset});
        end
        @(negedge clk);
        for (int i = 0; i < 12; i++)
            push_rec(CHW'($urandom_range(0, NCH - 1)), $urandom(), $urandom(),
                     DW'({$urandom(), $urandom()}), i == 11);
        idle_valid();
        wait_run();
        total++;
        if (stalls != 0) begin
            bad++; $display("FAIL b2b_stalls got %0d want 0", stalls);
        end
        total++;
        if (obs_q.size() != 12) begin
            bad++; $display("FAIL b2b_count got %0d want 12", obs_q.size());
        end
        foreach (exp_q[i]) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL b2b_write%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        total++;
        if (rec_count !== 32'd12) begin
            bad++; $display("FAIL b2b_rec_count got %0d want 12", rec_count);
        end
    endtask

    task automatic test_bad_channel();
        new_session();
        do_start();
        push_rec(3'd1, 32'd7, 32'd1, 48'h1111_2222_3333, 1'b0);
        push_rec(3'd5, 32'd7, 32'd2, 48'hDEAD_BEEF_0000, 1'b0);
        push_rec(3'd2, 32'd7, 32'd3, 48'h4444_5555_6666, 1'b1);
        idle_valid();
        wait_run();
        total++;
        if (obs_q.size() != 2) begin
            bad++; $display("FAIL badch_strobes got %0d want 2", obs_q.size());
        end
        foreach (exp_q[i]) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL badch_write%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        total++;
        if (rec_count !== 32'd2 || err_channel !== 1'b1) begin
            bad++; $display("FAIL badch_flags got count=%0d err=%b want 2/1", rec_count,
                            err_channel);
        end
    endtask

    task automatic test_abort();
        int n;
        new_session();
        do_start();
        total++;
        if (err_channel !== 1'b0) begin
            bad++; $display("FAIL err_cleared got %b want 0", err_channel);
        end
        for (int i = 0; i < 3; i++)
            push_rec(CHW'($urandom_range(0, 3)), $urandom(), $urandom(),
                     DW'({$urandom(), $urandom()}), i == 2);
        idle_valid();
        #1;
        n = obs_q.size();
        total++;
        if (busy !== 1'b1 || n != 2) begin
            bad++; $display("FAIL abort_pre got busy=%b strobes=%0d want 1/2", busy, n);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total++;
        if ({busy, done, wr_is_write} !== '0) begin
            bad++; $display("FAIL abort_idle got busy/done/strobe=%b want 0",
                            {busy, done, wr_is_write});
        end
        repeat (10) @(negedge clk);
        total++;
        if (obs_q.size() != n || en_rise_cyc != -1) begin
            bad++; $display("FAIL abort_quiet got strobes=%0d en_rise=%0d want %0d/-1",
                            obs_q.size(), en_rise_cyc, n);
        end
    endtask

    task automatic test_abort_wins();
        new_session();
        do_start();
        push_rec(3'd0, 32'd1, 32'd1, 48'h1, 1'b1);
        idle_valid();
        wait_run();
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done, controller_enable} !== 3'b000 || locrst_n != 1) begin
            bad++; $display("FAIL abort_wins got busy/done/en=%b locrst=%0d want 000/1",
                            {busy, done, controller_enable}, locrst_n);
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 4; s++) begin
            int n;
            new_session();
            do_start();
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) begin
                idle_valid();
                repeat ($urandom_range(0, 2)) @(negedge clk);
                push_rec(CHW'($urandom_range(0, 7)), $urandom(), $urandom(),
                         DW'({$urandom(), $urandom()}), i == n - 1);
            end
            idle_valid();
            wait_run();
            total++;
            if (obs_q.size() != exp_q.size()) begin
                bad++; $display("FAIL rand%0d_count got %0d want %0d", s, obs_q.size(),
                                exp_q.size());
            end
            foreach (exp_q[i]) begin
                total++;
                if (obs_q[i] !== exp_q[i]) begin
                    bad++; $display("FAIL rand%0d_write%0d got %h want %h", s, i, obs_q[i],
                                    exp_q[i]);
                end
            end
            total++;
            if (rec_count !== IW'(exp_cnt) || err_channel !== exp_err) begin
                bad++; $display("FAIL rand%0d_flags got count=%0d err=%b want %0d/%b", s,
                                rec_count, err_channel, exp_cnt, exp_err);
            end
`ifdef LOADER_CHECKSUM_EN
            total++;
            if (checksum !== exp_ck) begin
                bad++; $display("FAIL rand%0d_checksum got %h want %h", s, checksum, exp_ck);
            end
`endif
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        new_session();
        do_start();
        push_rec(3'd0, '0, '0, 48'hFFFF_0000_1234, 1'b0);
        push_rec(3'd1, '0, 32'd1, 48'h0F0F_0000_1234, 1'b1);
        idle_valid();
        wait_run();
        repeat (3) @(negedge clk);
        total++;
        if (checksum !== 48'hF0F0_0000_0000) begin
            bad++; $display("FAIL checksum got %h want f0f000000000", checksum);
        end
    endtask
`endif

    initial begin
        rec_if.rec_valid = 1'b0; rec_if.rec_channel = '0; rec_if.rec_layer = '0;
        rec_if.rec_row = '0; rec_if.rec_data = '0; rec_if.rec_last = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_bad_channel();
        test_abort();
        test_abort_wins();
        test_random();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
